// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the instruction/data memory arbiter
package mem_arbiter_pkg;
    typedef logic [31:0] u32_t;
    typedef logic [3:0]  wrstb_t;
    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'd0,
        MEM_OP_LOAD  = 2'd1,
        MEM_OP_STORE = 2'd2
    } mem_op_e;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } arb_state_e;
    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } arb_owner_e;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch (if_*) and data (mem_*) requests onto one memory bus (bus_*)
// Ports: clk/rst_n (async active-low); if_req/if_addr -> if_ack/if_rdata/if_err;
// mem_op/mem_addr/mem_wdata/mem_wrstb -> mem_ack/mem_rdata/mem_err;
// bus_req/bus_we/bus_addr/bus_wdata/bus_wrstb out, bus_ack/bus_rdata in.
// Optional macro ARB_TIMEOUT_EN: abort a bus wait after TIMEOUT_CYCLES cycles with err=1.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    if_req,
    input  u32_t    if_addr,
    output logic    if_ack,
    output u32_t    if_rdata,
    output logic    if_err,
    input  mem_op_e mem_op,
    input  u32_t    mem_addr,
    input  u32_t    mem_wdata,
    input  wrstb_t  mem_wrstb,
    output logic    mem_ack,
    output u32_t    mem_rdata,
    output logic    mem_err,
    output logic    bus_req,
    output logic    bus_we,
    output u32_t    bus_addr,
    output u32_t    bus_wdata,
    output wrstb_t  bus_wrstb,
    input  logic    bus_ack,
    input  u32_t    bus_rdata
);
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e state, state_nxt;
    arb_owner_e owner;
    u32_t       rdata_q;
    logic       timed_out;
    logic       err_q;
    logic       mem_go;
    logic       if_go;

    assign mem_go = state == IDLE && mem_op != MEM_OP_NONE;
    assign if_go  = state == IDLE && mem_op == MEM_OP_NONE && if_req;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt;
    // cnt counts completed ack-less BUS cycles; the last allowed one aborts
    assign timed_out = state == BUS && !bus_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state != BUS)
            cnt <= '0;
        else if (!bus_ack)
            cnt <= cnt + 1'b1;
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (mem_go || if_go) ? BUS : IDLE;
            BUS:     state_nxt = (bus_ack || timed_out) ? RESP : BUS;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWNER_IF;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wrstb <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (mem_go) begin
                owner     <= OWNER_MEM;
                bus_we    <= mem_op == MEM_OP_STORE;
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
                bus_wrstb <= mem_op == MEM_OP_STORE ? mem_wrstb : '0;
            end else if (if_go) begin
                owner     <= OWNER_IF;
                bus_we    <= 1'b0;
                bus_addr  <= if_addr;
                bus_wdata <= '0;
                bus_wrstb <= '0;
            end
            if (state == BUS && (bus_ack || timed_out)) begin
                rdata_q <= (bus_ack && !bus_we) ? bus_rdata : '0;
                err_q   <= timed_out;
            end
        end
    end

    assign bus_req   = state == BUS;
    assign if_ack    = state == RESP && owner == OWNER_IF;
    assign mem_ack   = state == RESP && owner == OWNER_MEM;
    assign if_rdata  = rdata_q;
    assign mem_rdata = rdata_q;
    assign if_err    = if_ack && err_q;
    assign mem_err   = mem_ack && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    if_req = 1'b0;
    u32_t    if_addr = '0;
    logic    if_ack;
    u32_t    if_rdata;
    logic    if_err;
    mem_op_e mem_op = MEM_OP_NONE;
    u32_t    mem_addr = '0;
    u32_t    mem_wdata = '0;
    wrstb_t  mem_wrstb = '0;
    logic    mem_ack;
    u32_t    mem_rdata;
    logic    mem_err;
    logic    bus_req;
    logic    bus_we;
    u32_t    bus_addr;
    u32_t    bus_wdata;
    wrstb_t  bus_wrstb;
    logic    bus_ack = 1'b0;
    u32_t    bus_rdata = '0;

    int n_checks = 0;
    int n_fail = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wrstb(mem_wrstb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wrstb(bus_wrstb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_mem_ack", 32'(mem_ack), 32'd0);
        check("rst_rdata", if_rdata, 32'd0);
        rst_n = 1'b1;
        step();

        // fetch only, bus_ack already high when bus_req rises
        if_req = 1'b1; if_addr = 32'h100; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        step();
        check("if_bus_req", 32'(bus_req), 32'd1);
        check("if_bus_addr", bus_addr, 32'h100);
        check("if_bus_we", 32'(bus_we), 32'd0);
        step();
        check("if_ack", 32'(if_ack), 32'd1);
        check("if_rdata", if_rdata, 32'hDEADBEEF);
        check("if_no_mem_ack", 32'(mem_ack), 32'd0);
        if_req = 1'b0; bus_ack = 1'b0;
        step();
        check("if_ack_one_cycle", 32'(if_ack), 32'd0);

        // simultaneous fetch and load: load first, fetch served afterwards
        if_req = 1'b1; if_addr = 32'h100; mem_op = MEM_OP_LOAD; mem_addr = 32'h2000;
        bus_ack = 1'b1; bus_rdata = 32'h11112222;
        step();
        check("arb_first_addr", bus_addr, 32'h2000);
        step();
        check("arb_mem_ack", 32'(mem_ack), 32'd1);
        check("arb_if_wait", 32'(if_ack), 32'd0);
        check("arb_mem_rdata", mem_rdata, 32'h11112222);
        mem_op = MEM_OP_NONE;
        step();
        check("arb_idle_gap", 32'(bus_req), 32'd0);
        bus_rdata = 32'h33334444;
        step();
        check("arb_second_addr", bus_addr, 32'h100);
        step();
        check("arb_if_ack", 32'(if_ack), 32'd1);
        check("arb_if_rdata", if_rdata, 32'h33334444);
        if_req = 1'b0; bus_ack = 1'b0;
        step();

        // store with three wait cycles
        mem_op = MEM_OP_STORE; mem_addr = 32'h40; mem_wdata = 32'h55AA1234; mem_wrstb = 4'b0011;
        step();
        check("st_bus_we", 32'(bus_we), 32'd1);
        mem_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("st_req_%0d", i), 32'(bus_req), 32'd1);
            check($sformatf("st_wrstb_%0d", i), 32'(bus_wrstb), 32'h3);
            if (i == 3) begin
                bus_ack = 1'b1;
                bus_rdata = 32'hFFFFFFFF;
            end
            step();
        end
        check("st_wdata_held", bus_wdata, 32'h55AA1234);
        check("st_mem_ack", 32'(mem_ack), 32'd1);
        check("st_mem_rdata", mem_rdata, 32'd0);
        check("st_mem_err", 32'(mem_err), 32'd0);
        mem_op = MEM_OP_NONE; bus_ack = 1'b0;
        step();

        // asynchronous reset in the middle of a bus wait
        mem_op = MEM_OP_LOAD; mem_addr = 32'h80;
        step();
        check("rb_bus_req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rb_req_drop", 32'(bus_req), 32'd0);
        check("rb_addr_clr", bus_addr, 32'd0);
        step();
        check("rb_no_ack", 32'(mem_ack), 32'd0);
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        step();
        check("rb_resample", bus_addr, 32'h80);
        step();
        check("rb_mem_ack", 32'(mem_ack), 32'd1);
        check("rb_mem_rdata", mem_rdata, 32'hCAFEF00D);
        mem_op = MEM_OP_NONE; bus_ack = 1'b0;
        step();

        // stray bus_ack while idle
        bus_ack = 1'b1;
        step();
        step();
        check("stray_bus_req", 32'(bus_req), 32'd0);
        check("stray_ack", 32'({if_ack, mem_ack}), 32'd0);
        bus_ack = 1'b0;
        step();

`ifdef ARB_TIMEOUT_EN
        mem_op = MEM_OP_LOAD; mem_addr = 32'h300;
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_req_%0d", i), 32'(bus_req), 32'd1);
            step();
        end
        check("to_req_drop", 32'(bus_req), 32'd0);
        check("to_mem_ack", 32'(mem_ack), 32'd1);
        check("to_mem_err", 32'(mem_err), 32'd1);
        check("to_mem_rdata", mem_rdata, 32'd0);
        mem_op = MEM_OP_NONE;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the bus-wait limit in cycles (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req  input  1  fetch read request, held until if_ack.
REQ-005 SHALL have port if_addr  input  32  fetch word address.
REQ-006 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port if_rdata  output  32  fetch data, valid with if_ack.
REQ-008 SHALL have port mem_op  input  2  mem_op_e; a value other than MEM_OP_NONE is a request, held until mem_ack.
REQ-009 SHALL have port mem_addr  input  32  data address.
REQ-010 SHALL have port mem_wdata  input  32  store data.
REQ-011 SHALL have port mem_wrstb  input  4  wrstb_t byte strobes for a store.
REQ-012 SHALL have port mem_ack  output  1  one-cycle data completion pulse.
REQ-013 SHALL have port mem_rdata  output  32  load data, valid with mem_ack.
REQ-014 SHALL have ports if_err and mem_err  output  1 each  bus-timeout flag, valid with the matching ack.
REQ-015 SHALL have ports bus_req, bus_we (output 1 each), bus_addr, bus_wdata (output 32 each), bus_wrstb (output 4): the shared memory port.
REQ-016 SHALL have ports bus_ack  input  1  and bus_rdata  input  32  from memory.

Function
REQ-017 SHALL implement FSM states IDLE, BUS, RESP.
REQ-018 IDLE: mem_op != NONE -> grant MEM; else if_req -> grant IF; else stay IDLE.
REQ-019 On grant: register addr/wdata/wrstb/we into bus outputs, record owner, go BUS; bus_req=1 from next cycle.
REQ-020 Fetch and load grants: bus_we=0, bus_wrstb=0; store grant: bus_we=1, bus_wrstb=mem_wrstb.
REQ-021 BUS: bus outputs held stable until the cycle bus_ack=1; on that edge register bus_rdata, drop bus_req, go RESP.
REQ-022 RESP: owner's ack=1 for exactly one cycle with registered rdata; other ack=0; next state IDLE.
REQ-023 Store responses SHALL return rdata=0.
REQ-024 Minimum latency: request sampled in IDLE cycle N, bus_req cycle N+1, ack cycle N+2 when bus_ack is at N+1.
REQ-025 A request still high in IDLE after its ack SHALL be treated as a new request.
REQ-026 Simultaneous IF and MEM in IDLE: MEM wins; IF waits, not dropped.
REQ-027 Requests arriving during BUS/RESP SHALL be ignored until IDLE.
REQ-028 bus_ack outside BUS SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, bus_req/bus_we=0, bus_addr/wdata/wrstb=0, all acks/errs=0, rdata regs=0, timeout counter=0, including mid-transaction.

Configuration
REQ-030 With ARB_TIMEOUT_EN defined: 8+-bit counter cleared on entering BUS, incremented each BUS cycle without bus_ack; reaching TIMEOUT_CYCLES drops bus_req, goes RESP with owner err=1 and rdata=0.
REQ-031 Without ARB_TIMEOUT_EN: BUS waits indefinitely; if_err and mem_err tied 0; no counter.

Structure
REQ-032 Shared types package SHALL hold arb_state_e (IDLE/BUS/RESP) and arb_owner_e (OWNER_IF/OWNER_MEM); mem_op_e, wrstb_t, u32_t reused from it.
REQ-033 Single flat module; no sub-module.

Verification
REQ-034 IF only, if_addr=0x100, bus_ack same cycle as bus_req, bus_rdata=0xDEADBEEF -> if_ack 2 cycles after sampling, if_rdata=0xDEADBEEF, bus_we=0.
REQ-035 IF and MEM load together (0x100, 0x2000) -> bus_addr=0x2000 first, mem_ack; then bus_addr=0x100, if_ack.
REQ-036 Store 0x55AA1234 at 0x40, wrstb=0b0011, bus_ack after 3 wait cycles -> bus_we=1, wrstb=0b0011 held 4 cycles, mem_ack, mem_rdata=0.
REQ-037 rst_n low during BUS -> bus_req=0 same cycle, no ack; after release, held request re-sampled and served.
REQ-038 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ack never -> bus_req drops after 4 cycles, mem_ack=1, mem_err=1, mem_rdata=0.
REQ-039 Stray bus_ack while IDLE -> no ack, state stays IDLE.
